// File: rtl/mnist_pkg.sv
// Shared constants, channel state type and the pixel weighting used by the classifier.
package mnist_pkg;

  localparam int IMG_PIXELS = 784;
  localparam int DIGIT_W    = 4;
  localparam int PIX_BYTE_W = 8;
  localparam int ADDR_W     = 10;

  localparam logic [ADDR_W-1:0] IMG_PIXELS_A = ADDR_W'(IMG_PIXELS);

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  // Each set pixel contributes (index mod 13) + 1; the digit is the sum mod 16.
  function automatic logic [DIGIT_W-1:0] pix_weight(input int idx);
    return DIGIT_W'((idx % 13) + 1);
  endfunction

endpackage

// File: rtl/mnist_arbiter.sv
// Round-robin result arbiter; a pop can hand over to the next DONE channel in the same edge.
module mnist_arbiter
  import mnist_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   done,
  input  logic [DIGIT_W-1:0]  digits [NUM_CH],
  input  logic                res_ready,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [DIGIT_W-1:0]  res_digit,
  output logic [NUM_CH-1:0]   pop
);

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   base;
  logic [CH_W-1:0]   sel;
  logic [NUM_CH-1:0] cand;
  logic              popping;
  logic              found;
  int                idx;

  assign popping = res_valid && res_ready;

  always_comb begin
    pop = '0;
    if (popping) pop[res_ch] = 1'b1;
  end

  // Search starts one past the last popped channel and wraps.
  always_comb begin
    base  = popping ? res_ch : rr_ptr;
    cand  = done & ~pop;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(base) + i) % NUM_CH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_digit <= '0;
    end else begin
      if (popping) rr_ptr <= res_ch;
      if (!res_valid || popping) begin
        res_valid <= found;
        if (found) begin
          res_ch    <= sel;
          res_digit <= digits[sel];
        end
      end
    end
  end

endmodule

// File: rtl/mnist_channel.sv
// One classifier channel: image buffer, IDLE/RUN/DONE FSM, latency down-counter, classifier.
// MNIST_AUTOCLEAR_EN: when defined, the image is wiped on the cycle the result is popped.
//
// state   | meaning
// IDLE    | image writable, waiting for start
// RUN     | image frozen, counting CLS_LATENCY cycles
// DONE    | digit latched, waiting for the arbiter to pop it
module mnist_channel
  import mnist_pkg::*;
#(
  parameter int THRESHOLD   = 128,
  parameter int CLS_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [PIX_BYTE_W-1:0] wr_data,
  input  logic                  start,
  input  logic                  pop,
  output logic                  busy,
  output logic                  done,
  output logic [DIGIT_W-1:0]    digit
);

  localparam int CNT_W = (CLS_LATENCY > 1) ? $clog2(CLS_LATENCY) : 1;

  ch_state_t              state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [IMG_PIXELS-1:0]  image;
  logic [DIGIT_W-1:0]     cls_digit;
  logic                   run_last;
  logic                   img_we;
  logic                   wr_bit;

  assign wr_bit = (int'(wr_data) >= THRESHOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CH_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE: if (start)         state_nxt = CH_RUN;
      CH_RUN:  if (cnt == '0)     state_nxt = CH_DONE;
      CH_DONE: if (pop)           state_nxt = CH_IDLE;
      default:                    state_nxt = CH_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != CH_IDLE);
    done     = (state == CH_DONE);
    run_last = (state == CH_RUN) && (cnt == '0);
    img_we   = wr_en && (state == CH_IDLE) && (wr_addr < IMG_PIXELS_A);
  end

  // Loaded with CLS_LATENCY-1 so RUN lasts exactly CLS_LATENCY cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == CH_IDLE) && start) begin
      cnt <= CNT_W'(CLS_LATENCY - 1);
    end else if ((state == CH_RUN) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image <= '0;
    end else if (img_we) begin
      image[wr_addr] <= wr_bit;
`ifdef MNIST_AUTOCLEAR_EN
    end else if (done && pop) begin
      image <= '0;
`else
    end else begin
      image <= image;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           digit <= '0;
    else if (run_last) digit <= cls_digit;
  end

  mnist_classifier u_cls (
    .image (image),
    .digit (cls_digit)
  );

endmodule

// File: rtl/mnist_classifier.sv
// Combinational classifier: weighted pixel sum folded to DIGIT_W bits (values 10..15 possible).
module mnist_classifier
  import mnist_pkg::*;
(
  input  logic [IMG_PIXELS-1:0] image,
  output logic [DIGIT_W-1:0]    digit
);

  logic [DIGIT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < IMG_PIXELS; i++) begin
      if (image[i]) acc = acc + pix_weight(i);
    end
    digit = acc;
  end

endmodule

// File: rtl/mnist_batch_runner.sv
// Multi-channel MNIST batch runner: pixel write port, per-channel start, round-robin result port.
// MNIST_AUTOCLEAR_EN (see mnist_channel) wipes a channel's image when its result is popped.
module mnist_batch_runner
  import mnist_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int THRESHOLD   = 128,
  parameter  int CLS_LATENCY = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [PIX_BYTE_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]     start,
  output logic [NUM_CH-1:0]     busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CH_W-1:0]       res_ch,
  output logic [DIGIT_W-1:0]    res_digit
);

  logic                 wr_in_range;
  logic [NUM_CH-1:0]    wr_en;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_pop;
  logic [DIGIT_W-1:0]   ch_digit [NUM_CH];

  // Out-of-range channels always accept and drop the write.
  assign wr_in_range = (int'(wr_ch) < NUM_CH);
  assign wr_ready    = wr_in_range ? ~busy[wr_ch] : 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_en[c] = wr_valid && wr_ready && wr_in_range && (wr_ch == CH_W'(c));

    mnist_channel #(
      .THRESHOLD   (THRESHOLD),
      .CLS_LATENCY (CLS_LATENCY)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[c]),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start[c]),
      .pop     (ch_pop[c]),
      .busy    (busy[c]),
      .done    (ch_done[c]),
      .digit   (ch_digit[c])
    );
  end

  mnist_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .done      (ch_done),
    .digits    (ch_digit),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_digit (res_digit),
    .pop       (ch_pop)
  );

endmodule

// File: tb/tb_mnist_batch_runner.sv
// Directed + randomized bench for mnist_batch_runner against a pixel-array reference model.
module tb_mnist_batch_runner;

  localparam int NCH = 4;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_ch = '0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] start = '0;
  logic [3:0] busy;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_ch;
  logic [3:0] res_digit;

  int total = 0;
  int passed = 0;

  bit img [NCH][784];

  mnist_batch_runner #(.NUM_CH(NCH), .THRESHOLD(128), .CLS_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_digit(res_digit)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int model_digit(input int ch);
    int s = 0;
    for (int i = 0; i < 784; i++) if (img[ch][i]) s += (i % 13) + 1;
    return s % 16;
  endfunction

  task automatic model_pop(input int ch);
`ifdef MNIST_AUTOCLEAR_EN
    for (int i = 0; i < 784; i++) img[ch][i] = 1'b0;
`else
    if (ch < 0) $display("note: no channel");
`endif
  endtask

  task automatic do_write(input int ch, input int addr, input int data);
    @(negedge clk);
    wr_valid = 1'b1; wr_ch = 2'(ch); wr_addr = 10'(addr); wr_data = 8'(data);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    if (addr < 784) img[ch][addr] = (data >= 128);
  endtask

  task automatic do_start(input logic [3:0] m);
    @(negedge clk);
    start = m;
    @(posedge clk);
    #1 start = '0;
  endtask

  task automatic pop_one(output int ch, output int dig, input int hold);
    int n = 0;
    ch = -1; dig = -1;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("res_seen", {31'd0, res_valid}, 1);
    if (res_valid) begin
      ch = int'(res_ch); dig = int'(res_digit);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_ch", res_ch, ch);
        chk("hold_digit", res_digit, dig);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      model_pop(ch);
    end
  endtask

  task automatic run_check(input int ch, input string tag);
    int c, d, e;
    e = model_digit(ch);
    do_start(4'(1 << ch));
    pop_one(c, d, 0);
    chk({tag, "_ch"}, c, ch);
    chk({tag, "_digit"}, d, e);
  endtask

  initial begin
    int c, d, e1, e3, n, mask, cnt;
    int exp_d [NCH];
    bit pending [NCH];
    bit saw;

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_res_digit", res_digit, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // all-ones image on ch2, zeros elsewhere
    for (int ch = 0; ch < NCH; ch++)
      for (int a = 0; a < 784; a++) do_write(ch, a, (ch == 2) ? 200 : 0);
    e1 = model_digit(2);
    do_start(4'b0100);
    chk("ones_busy_k0", busy[2], 1);
    chk("ones_valid_k0", res_valid, 0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      chk("ones_busy", busy[2], 1);
      chk("ones_valid", res_valid, (k == LAT + 1) ? 1 : 0);
    end
    chk("ones_ch", res_ch, 2);
    chk("ones_digit", res_digit, e1);
    @(negedge clk) res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    model_pop(2);
    chk("ones_busy_after_pop", busy[2], 0);
    chk("ones_valid_after_pop", res_valid, 0);

    // threshold boundary on pixel 5
    do_write(0, 5, 127);
    run_check(0, "thr127");
    do_write(0, 5, 128);
    run_check(0, "thr128");

    // write while RUN is refused, out-of-range address is dropped
    e1 = model_digit(0);
    do_start(4'b0001);
    @(negedge clk);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 10'd6; wr_data = 8'd255;
    #1 chk("wr_ready_run", wr_ready, 0);
    @(posedge clk); #1 wr_valid = 1'b0;
    pop_one(c, d, 0);
    chk("run_write_digit", d, e1);
    @(negedge clk);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 10'd900; wr_data = 8'd255;
    #1 chk("wr_ready_addr900", wr_ready, 1);
    @(posedge clk); #1 wr_valid = 1'b0;
    run_check(0, "addr900");

    // simultaneous start of ch1/ch3 with back-pressure
    for (int i = 0; i < 40; i++)
      do_write((i % 2) ? 3 : 1, $urandom_range(0, 783), $urandom_range(0, 255));
    e1 = model_digit(1);
    e3 = model_digit(3);
    do_start(4'b1010);
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_ch", res_ch, 1);
      chk("bp_digit", res_digit, e1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second_valid", res_valid, 1);
    chk("bp_second_ch", res_ch, 3);
    chk("bp_second_digit", res_digit, e3);
    chk("bp_ch1_idle", busy[1], 0);
    model_pop(1);
    @(posedge clk); #1 res_ready = 1'b0;
    chk("bp_drained", res_valid, 0);
    chk("bp_ch3_idle", busy[3], 0);
    model_pop(3);

    // reset mid-RUN abandons the result
    do_start(4'b0001);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int ch = 0; ch < NCH; ch++)
      for (int a = 0; a < 784; a++) img[ch][a] = 1'b0;
    #1;
    chk("rrst_busy", busy, 0);
    chk("rrst_valid", res_valid, 0);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || busy != 0) saw = 1'b1;
    end
    chk("rrst_no_late_result", {31'd0, saw}, 0);

    // re-start without writes: retained image vs autoclear
    for (int i = 0; i < 20; i++) do_write(0, $urandom_range(0, 783), $urandom_range(0, 255));
    if (model_digit(0) == 0) do_write(0, 0, img[0][0] ? 0 : 255);
    run_check(0, "ac_first");
    run_check(0, "ac_restart");

    // randomized batches
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 25; i++)
        do_write($urandom_range(0, NCH - 1), $urandom_range(0, 1023), $urandom_range(0, 255));
      mask = $urandom_range(1, 15);
      cnt = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        pending[ch] = mask[ch];
        exp_d[ch] = model_digit(ch);
        if (mask[ch]) cnt++;
      end
      do_start(4'(mask));
      for (int j = 0; j < cnt; j++) begin
        pop_one(c, d, $urandom_range(0, 3));
        if (c >= 0) begin
          chk("rnd_started", {31'd0, pending[c]}, 1);
          chk("rnd_digit", d, exp_d[c]);
          pending[c] = 1'b0;
        end
      end
      @(negedge clk);
      chk("rnd_all_idle", busy, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
